// File: rtl/eye_bin_pkg.sv
// Shared definitions for the eye-region binarizer: geometry defaults, the
// statistics FSM encoding and width helpers for the accumulator and pixel counter.
package eye_bin_pkg;

  localparam int DEF_H_ACT   = 640;
  localparam int DEF_V_ACT   = 480;
  localparam int PIX_TOTAL   = DEF_H_ACT * DEF_V_ACT;
  localparam int THR_DEFAULT = 100;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCUM     = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  // Smallest width that holds a full frame of 8-bit pixels summed.
  function automatic int sum_width(input int h_act, input int v_act);
    return $clog2(255 * h_act * v_act + 1);
  endfunction

  function automatic int cnt_width(input int h_act, input int v_act);
    return $clog2(h_act * v_act + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses W cycles
// after start with the quotient held until the next start.
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W:0]    rem_shift;
  logic [W:0]    diff;
  logic [CW-1:0] cnt;

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    rem_shift = {rem, quotient[W-1]};
    diff      = rem_shift - {1'b0, divisor};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem      <= '0;
        quotient <= dividend;
        cnt      <= CW'(W);
        busy     <= 1'b1;
      end else if (busy) begin
        if (!diff[W]) begin
          rem      <= diff[W-1:0];
          quotient <= {quotient[W-2:0], 1'b1};
        end else begin
          rem      <= rem_shift[W-1:0];
          quotient <= {quotient[W-2:0], 1'b0};
        end
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eye_binarize.sv
// Thresholds the eye-region grayscale stream to 1-bit data for morph_treatment,
// with a per-frame threshold of (frame mean - offset) computed during blanking.
module eye_binarize
  import eye_bin_pkg::*;
#(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int DEF_THR = THR_DEFAULT,
  parameter int SUM_W   = sum_width(H_ACT, V_ACT),
  parameter int CNT_W   = cnt_width(H_ACT, V_ACT)
) (
  input  logic       module_clk,
  input  logic       module_rst,
  input  logic       frame_start,
  input  logic       pix_val,
  input  logic [7:0] pix_gray,
  input  logic [7:0] thr_offset,
  input  logic       thr_manual_en,
  input  logic [7:0] thr_manual,
  output logic       data_val,
  output logic       row_data,
  output logic [7:0] cur_thr,
  output logic       frame_done,
  output logic [7:0] auto_thr,
  output state_t     state
);

  localparam int PIX_TOT = H_ACT * V_ACT;

  // Handshake: frame_start is a one-cycle blanking pulse; pix_val qualifies
  // pix_gray on the same cycle; there is no backpressure toward the source.
  state_t           state_next;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] dividend;
  logic [SUM_W-1:0] quotient;
  logic [CNT_W-1:0] pix_cnt;
  logic             acc_en;
  logic             div_start;
  logic             div_done;
  logic             div_busy;
  logic [7:0]       mean;

  always_ff @(posedge module_clk) begin
    if (module_rst) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (frame_start)    state_next = ACCUM;
    else if (div_start) state_next = DONE_WAIT;
  end

  // A pixel coinciding with frame_start belongs to no frame and is not counted.
  always_comb begin
    acc_en    = (state == ACCUM) && pix_val && !frame_start;
    div_start = acc_en && (pix_cnt == CNT_W'(PIX_TOT - 1));
    dividend  = sum + SUM_W'(pix_gray);
  end

  always_ff @(posedge module_clk) begin
    if (module_rst || frame_start) begin
      sum     <= '0;
      pix_cnt <= '0;
    end else if (acc_en) begin
      sum     <= dividend;
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end

  seq_divider #(.W(SUM_W)) u_div (
    .clk      (module_clk),
    .rst      (module_rst),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (SUM_W'(PIX_TOT)),
    .quotient (quotient),
    .done     (div_done),
    .busy     (div_busy)
  );

  assign mean       = (quotient > SUM_W'(255)) ? 8'hFF : quotient[7:0];
  assign frame_done = div_done;

  always_ff @(posedge module_clk) begin
    if (module_rst) begin
      data_val <= 1'b0;
      row_data <= 1'b0;
      cur_thr  <= 8'(DEF_THR);
      auto_thr <= 8'(DEF_THR);
    end else begin
      data_val <= pix_val;
      row_data <= pix_val && (pix_gray <= cur_thr);
      if (frame_start) cur_thr <= thr_manual_en ? thr_manual : auto_thr;
      if (div_done)    auto_thr <= (mean > thr_offset) ? mean - thr_offset : 8'd0;
    end
  end

  // A frame is far longer than a divide, so start never lands on a busy divider.
  always @(posedge module_clk) begin
    if (!module_rst && div_start) assert (!div_busy);
  end

endmodule

// File: tb/tb_eye_binarize.sv
// Directed-plus-random bench for eye_binarize on an 8x4 frame, checked against
// a frame-level model of the threshold and binarize rules.
module tb_eye_binarize;
  import eye_bin_pkg::*;

  localparam int H = 8, V = 4, TOT = 32, SW = 13, CW = 6, DEF = 100, DIV_LAT = 13;

  logic       clk = 1'b0;
  logic       module_rst, frame_start, pix_val, thr_manual_en;
  logic [7:0] pix_gray, thr_offset, thr_manual;
  logic       data_val, row_data, frame_done;
  logic [7:0] cur_thr, auto_thr;
  state_t     state;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, last_done_cyc = -1000, last_pix_cyc = 0;
  int model_cur = DEF, model_auto = DEF, pend_sum = 0, pend_mean = 0;
  logic [7:0] frame_q[$];
  logic [0:0] exp_q[$];

  eye_binarize #(.H_ACT(H), .V_ACT(V), .DEF_THR(DEF), .SUM_W(SW), .CNT_W(CW)) dut (
    .module_clk(clk), .module_rst(module_rst), .frame_start(frame_start),
    .pix_val(pix_val), .pix_gray(pix_gray), .thr_offset(thr_offset),
    .thr_manual_en(thr_manual_en), .thr_manual(thr_manual),
    .data_val(data_val), .row_data(row_data), .cur_thr(cur_thr),
    .frame_done(frame_done), .auto_thr(auto_thr), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (frame_done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pend_sum  = 0;
    model_cur = thr_manual_en ? int'(thr_manual) : model_auto;
    check("cur_thr_latch", cur_thr, model_cur);
  endtask

  task automatic drive_pix(input logic [7:0] g);
    logic [0:0] e;
    pix_val  = 1'b1;
    pix_gray = g;
    exp_q.push_back(int'(g) <= model_cur);
    tick();
    pix_val = 1'b0;
    e = exp_q.pop_front();
    check("data_val", data_val, 1);
    check("row_data", row_data, e);
  endtask

  // Drive frame_q[lo..hi]; the final pixel closes the frame's statistics.
  task automatic feed(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive_pix(frame_q[i]);
      pend_sum += int'(frame_q[i]);
    end
    if (hi == TOT - 1) begin
      pend_mean    = (pend_sum / TOT > 255) ? 255 : pend_sum / TOT;
      last_pix_cyc = cyc;
    end
  endtask

  task automatic wait_update(input string tag);
    int start_cnt = done_cnt;
    int n = 0;
    while (done_cnt == start_cnt && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt - start_cnt, 1);
    check({tag, "_done_latency"}, last_done_cyc - last_pix_cyc, DIV_LAT);
    model_auto = (pend_mean > int'(thr_offset)) ? pend_mean - int'(thr_offset) : 0;
    tick();
    check({tag, "_auto_thr"}, auto_thr, model_auto);
    check({tag, "_done_one_cycle"}, frame_done, 0);
  endtask

  task automatic fill_rand(input int zero_odds);
    frame_q.delete();
    for (int i = 0; i < TOT; i++)
      frame_q.push_back(($urandom_range(0, zero_odds) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    module_rst = 1'b1; frame_start = 1'b0; pix_val = 1'b0; pix_gray = '0;
    thr_offset = '0; thr_manual_en = 1'b0; thr_manual = '0;
    repeat (3) tick();
    check("rst_data_val", data_val, 0);
    check("rst_row_data", row_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_cur_thr", cur_thr, DEF);
    check("rst_auto_thr", auto_thr, DEF);
    check("rst_state", state, IDLE);
    module_rst = 1'b0;
    tick();

    // 1: binarize runs from IDLE with the default threshold
    drive_pix(8'd100);
    drive_pix(8'd101);
    tick();
    check("s1_idle_data_val", data_val, 0);
    check("s1_idle_row_data", row_data, 0);
    check("s1_cur_thr", cur_thr, DEF);

    // 2: uniform frame
    thr_offset = 8'd20;
    start_frame();
    frame_q.delete();
    for (int i = 0; i < TOT; i++) frame_q.push_back(8'd120);
    feed(0, TOT - 1);
    wait_update("s2");
    check("s2_auto_100", auto_thr, 100);
    start_frame();

    // 3: ramp frame floors to zero, then only zero pixels are dark
    thr_offset = 8'd200;
    frame_q.delete();
    for (int i = 0; i < TOT; i++) frame_q.push_back(8'(8 * i));
    feed(0, TOT - 1);
    wait_update("s3");
    check("s3_auto_0", auto_thr, 0);
    start_frame();
    thr_offset = 8'($urandom_range(0, 255));
    fill_rand(2);
    feed(0, TOT - 1);
    wait_update("s3r");

    // 4: truncated frame is discarded
    cnt0 = done_cnt;
    thr_offset = 8'd10;
    start_frame();
    for (int i = 0; i < 20; i++) drive_pix(8'd200);
    start_frame();
    frame_q.delete();
    for (int i = 0; i < TOT; i++) frame_q.push_back(8'd60);
    feed(0, TOT - 1);
    wait_update("s4");
    repeat (20) tick();
    check("s4_done_count", done_cnt - cnt0, 1);
    check("s4_auto_50", auto_thr, 50);

    // 5: manual threshold held for the whole frame
    thr_manual_en = 1'b1;
    thr_manual    = 8'd30;
    thr_offset    = 8'($urandom_range(0, 255));
    start_frame();
    fill_rand(4);
    feed(0, 15);
    thr_manual = 8'd90;
    tick();
    check("s5_cur_hold", cur_thr, 30);
    feed(16, TOT - 1);
    wait_update("s5");
    start_frame();
    check("s5_cur_90", cur_thr, 90);
    thr_manual_en = 1'b0;

    // 7: frame_start during a divide latches the previous auto threshold
    thr_offset = 8'($urandom_range(0, 60));
    start_frame();
    fill_rand(6);
    feed(0, TOT - 1);
    repeat (2) tick();
    start_frame();
    wait_update("s7");
    start_frame();

    // 6: reset mid-divide
    fill_rand(6);
    feed(0, TOT - 1);
    repeat (5) tick();
    module_rst = 1'b1;
    pix_val    = 1'b1;
    pix_gray   = 8'd0;
    tick();
    module_rst = 1'b0;
    pix_val    = 1'b0;
    cnt0 = done_cnt;
    model_auto = DEF;
    model_cur  = DEF;
    check("s6_data_val", data_val, 0);
    check("s6_frame_done", frame_done, 0);
    check("s6_auto_thr", auto_thr, model_auto);
    check("s6_cur_thr", cur_thr, model_cur);
    check("s6_state", state, IDLE);
    repeat (30) tick();
    check("s6_no_done", done_cnt - cnt0, 0);
    check("s6_auto_hold", auto_thr, DEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eye_binarize.md
Name: eye_binarize

Overview:
- Stage directly upstream of morph_treatment.
- Takes the 8-bit grayscale pixel stream of the eye region and thresholds it into the 1-bit `row_data`/`data_val` stream that morph_treatment consumes.
- The threshold adapts per frame: the frame mean minus a programmable offset, computed during vertical blanking by a sequential divider.
- A manual threshold override is available for bring-up.

Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- DEF_THR, 100, threshold used after reset until the first auto update.
- SUM_W, 27, accumulator width; must satisfy 2^SUM_W > 255*H_ACT*V_ACT.
- CNT_W, 19, pixel counter width; must satisfy 2^CNT_W > H_ACT*V_ACT.

Ports:
- module_clk  in  1  system clock.
- module_rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse in blanking before each frame's first pixel.
- pix_val  in  1  pixel valid.
- pix_gray  in  8  grayscale pixel, sampled when pix_val=1.
- thr_offset  in  8  subtracted from the frame mean.
- thr_manual_en  in  1  1 selects thr_manual instead of the auto threshold.
- thr_manual  in  8  manual threshold.
- data_val  out  1  binarized data valid (to morph_treatment).
- row_data  out  1  binarized pixel; 1 means dark.
- cur_thr  out  8  threshold applied to the current frame.
- frame_done  out  1  one-cycle pulse when a new auto threshold is written.

Behaviour:
- Reset is synchronous, active-high, and has priority over everything. Reset values:
  - data_val=0, row_data=0, frame_done=0.
  - cur_thr=DEF_THR, auto_thr=DEF_THR.
  - state=IDLE; sum, pix_cnt and divider cleared.
- Binarize path, fixed 1-cycle latency:
  - data_val <= pix_val.
  - row_data <= pix_val & (pix_gray <= cur_thr).
  - row_data is 0 whenever data_val is 0.
  - The binarize path runs in every state, including IDLE.
- Threshold latch:
  - On frame_start, cur_thr <= thr_manual_en ? thr_manual : auto_thr.
  - cur_thr does not change mid-frame, even if thr_manual, thr_manual_en or auto_thr change.
- Statistics FSM (states IDLE, ACCUM, DONE_WAIT):
  - IDLE: entered after reset. On frame_start: clear sum and pix_cnt, go to ACCUM.
  - ACCUM: each pix_val cycle does sum += pix_gray and pix_cnt += 1. When the accepted pixel makes pix_cnt == H_ACT*V_ACT:
    - hand the final sum to the divider (start pulse, dividend latched inside the divider);
    - go to DONE_WAIT.
  - ACCUM, frame_start before the count completes: truncated frame. Discard the statistics, clear sum and pix_cnt, stay in ACCUM. No divide is started and auto_thr is unchanged.
  - DONE_WAIT: extra pix_val pixels are binarized but not accumulated. On frame_start: clear sum and pix_cnt, go to ACCUM.
- Divider:
  - Unsigned restoring divider: dividend SUM_W bits, divisor constant PIX_TOTAL=H_ACT*V_ACT.
  - Exactly SUM_W cycles after start; quotient truncated, saturated to 255.
  - The divider is independent of the accumulator, so frame_start arriving during a divide starts the next accumulation immediately.
  - The divide still completes. cur_thr latched at that frame_start uses the old auto_thr; the new value applies from the following frame.
- Update, on the cycle the divider asserts done:
  - auto_thr <= (mean > thr_offset) ? mean - thr_offset : 0.
  - frame_done=1 for exactly one cycle.
  - The update happens regardless of thr_manual_en.
- Start and busy: a new divide start cannot occur while busy, because one frame is far longer than SUM_W cycles. The implementation asserts this in simulation only.
- Arithmetic width: sum never overflows by the SUM_W constraint.
- Reset mid-divide: the divider aborts, no frame_done, auto_thr=DEF_THR.

Decomposition:
- Package eye_bin_pkg holds:
  - PIX_TOTAL = H_ACT*V_ACT;
  - the state encoding (IDLE=2'd0, ACCUM=2'd1, DONE_WAIT=2'd2);
  - the DEF_THR default;
  - SUM_W and CNT_W derivation helpers.
- One sub-module, seq_divider:
  - generic unsigned restoring divider;
  - ports: clk, rst, start, dividend, divisor, quotient, done, busy.
  - Reusable later for the eye-openness ratio stage.

Test Plan:
- Use H_ACT=8, V_ACT=4, PIX_TOTAL=32, SUM_W=13, CNT_W=6 in all scenarios.
1. After reset, drive pix_val with pix_gray=100 then 101, no frame_start:
   - row_data 1 then 0, each 1 cycle after the input;
   - data_val tracks pix_val delayed by one cycle;
   - cur_thr=100.
2. Uniform frame, all 32 pixels = 120, thr_offset=20:
   - exactly 13 cycles after the 32nd pixel, frame_done pulses once and auto_thr=100;
   - after the next frame_start, cur_thr=100.
3. Ramp frame, pixel k = 8*k for k=0..31 (sum 3968, mean 124), thr_offset=200:
   - auto_thr=0 (floored);
   - in the next frame, only pixels equal to 0 give row_data=1.
4. Truncated frame: frame_start after 20 pixels of value 200, then a full frame of value 60 with thr_offset=10:
   - exactly one frame_done;
   - auto_thr=50, not influenced by the 200s.
5. thr_manual_en=1, thr_manual=30; change thr_manual to 90 mid-frame:
   - cur_thr stays 30 until the next frame_start, then 90;
   - auto update still pulses frame_done.
6. Assert module_rst 5 cycles into a divide:
   - no frame_done;
   - auto_thr and cur_thr return to DEF_THR;
   - data_val=0 on the cycle after reset.
